sll64_seq: RTL and testbench
============================

Name: sll64_seq

Overview:
- Multi-cycle 64-bit logical left shifter; the left-direction counterpart of the team's combinational 64-bit arithmetic right shifter.
- Used by the execute stage when the shift unit is time-multiplexed: one log-shifter stage is resolved per clock.
- Start/done handshake to the ALU controller; result is registered and has a zero flag.
- Zero-fill from the LSB side; the upper bits of in2 are ignored, exactly as in the right shifter.

Parameters:
- WIDTH, 64, operand/result width in bits.
- SHW, 6, shift-amount width; must equal log2(WIDTH); only in2[SHW-1:0] is used.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst  input  1  synchronous active-high reset.
- start  input  1  request; sampled on a rising edge while the unit is ready (IDLE or DONE).
- in1  input  WIDTH  operand to be shifted; captured on the accepted start.
- in2  input  WIDTH  shift amount; only in2[SHW-1:0] is captured on the accepted start.
- busy  output  1  high while in SHIFT.
- done  output  1  one-cycle pulse; out and z_sll_flag are valid and updated from this cycle.
- out  output  WIDTH  registered result, held until the next completion.
- z_sll_flag  output  1  registered; 1 when the completed result is all zeros.

Behaviour:
- Reset: rst high at a rising edge forces state IDLE, busy=0, done=0, out=0, z_sll_flag=0, and clears internal data/amount/stage registers. Reset wins over start and aborts an operation in flight; no done is produced for the aborted request.
- States and transitions:
  - IDLE: busy=0, done=0. start=1 -> capture acc<=in1, amt<=in2[SHW-1:0], stage<=0, go to SHIFT. start=0 -> stay in IDLE.
  - SHIFT: busy=1. Each cycle: if amt[stage]=1, acc <= acc << 2^stage (zero fill); otherwise acc is unchanged. stage increments each cycle. When stage=SHW-1: out<=new acc, z_sll_flag<=(new acc==0), go to DONE. start is ignored in SHIFT; no queuing.
  - DONE: done=1, busy=0. start=1 -> capture new operands and go to SHIFT (back-to-back). start=0 -> go to IDLE.
- Latency: accepted start at edge N gives done=1 in the cycle after edge N+SHW; for the default SHW, done is high 6 cycles after the accepting edge. Latency is fixed regardless of amount, including amount 0.
- Throughput: one result per SHW+1 cycles with start held high.
- Arithmetic: result = (in1 << in2[5:0]) mod 2^64. Bits shifted past the MSB are discarded. Amount 0 passes in1 through unchanged. Amount 63 leaves only in1[0], at bit 63.
- out and z_sll_flag change only at the DONE transition or on reset; they are stable during SHIFT, IDLE and DONE.
- Inputs in1/in2 may change freely after the accepting edge without affecting the result.

Test Plan:
- rst held 2 cycles then released, start=0 -> out=0, z_sll_flag=0, busy=0, done=0 indefinitely.
- in1=0x0000_0000_0000_0001, in2=0x3F, start pulse -> done after 6 cycles. out=0x8000_0000_0000_0000, z_sll_flag=0, busy high for exactly 6 cycles.
- in1=0xFFFF_FFFF_FFFF_FFFF, in2=0x0000_0000_0000_0104 (only amount 4 used) -> out=0xFFFF_FFFF_FFFF_FFF0.
- in1=0xF000_0000_0000_0000, in2=4 -> out=0, z_sll_flag=1. Then in1=0x1234_5678_9ABC_DEF0, in2=0 -> out=0x1234_5678_9ABC_DEF0, z_sll_flag=0.
- start held high over two requests (A: in1=0x3, in2=1; B: in1=0x1, in2=32) -> done pulses 7 cycles apart. out=0x6 at the first done, out=0x1_0000_0000 at the second. Any start pulses asserted during SHIFT are ignored.
- rst asserted at the 3rd SHIFT cycle -> IDLE next cycle, out=0, no done pulse. A fresh start afterwards completes normally.
- Random check: 1000 random in1/in2 pairs compared against the reference model (in1 << in2[5:0]) and its zero flag.

Source files
------------

// File: rtl/sll64_seq_if.sv
// Start/done handshake and operand/result bundle
// between the ALU controller and sll64_seq.
interface sll64_seq_if #(
  parameter int WIDTH = 64
);
  logic             start;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] out;
  logic             z_sll_flag;

  modport master (
    output start, in1, in2,
    input  busy, done, out, z_sll_flag
  );

  modport slave (
    input  start, in1, in2,
    output busy, done, out, z_sll_flag
  );
endinterface

// File: rtl/sll64_seq.sv
// Multi-cycle logical left shifter: one log-shifter
// stage per clock, registered result and zero flag.
module sll64_seq #(
  parameter int WIDTH = 64,
  parameter int SHW   = 6
) (
  input logic        clk,
  input logic        rst,
  sll64_seq_if.slave bus
);
  localparam int STW = $clog2(SHW);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t           state;
  state_t           state_n;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_n;
  logic [WIDTH-1:0] res;
  logic [SHW-1:0]   amt;
  logic [STW-1:0]   stage;
  logic             z;
  logic             load;
  logic             last;
  logic             unused_in2;

  assign last = (stage == STW'(SHW - 1));

  // Stage k shifts by 2^k when amount bit k is set.
  always_comb begin
    acc_n = acc;
    if (amt[stage])
      acc_n = acc << (SHW'(1) << stage);
  end

  always_comb begin
    state_n = state;
    load    = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          state_n = SHIFT;
          load    = 1'b1;
        end
      end
      SHIFT: begin
        if (last)
          state_n = DONE;
      end
      DONE: begin
        load    = bus.start;
        state_n = bus.start ? SHIFT : IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc   <= '0;
      amt   <= '0;
      stage <= '0;
      res   <= '0;
      z     <= 1'b0;
    end else if (load) begin
      acc   <= bus.in1;
      amt   <= bus.in2[SHW-1:0];
      stage <= '0;
    end else if (state == SHIFT) begin
      acc   <= acc_n;
      stage <= last ? '0 : stage + STW'(1);
      if (last) begin
        res <= acc_n;
        z   <= (acc_n == '0);
      end
    end
  end

  assign bus.busy       = (state == SHIFT);
  assign bus.done       = (state == DONE);
  assign bus.out        = res;
  assign bus.z_sll_flag = z;

  assign unused_in2 = ^bus.in2[WIDTH-1:SHW];
endmodule

// File: tb/tb_sll64_seq.sv
// Directed and random checks of sll64_seq against
// hand-computed values and a one-line shift model.
module tb_sll64_seq;
  logic clk = 1'b0;
  logic rst;
  int   compared   = 0;
  int   mismatched = 0;

  sll64_seq_if #(.WIDTH(64)) bus ();

  sll64_seq #(.WIDTH(64), .SHW(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [63:0] obs,
                     logic [63:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  task automatic run_op(string tag, logic [63:0] a,
                        logic [63:0] b, logic [63:0] eo,
                        logic ez);
    int n;
    int nb;
    @(negedge clk);
    bus.start = 1'b1;
    bus.in1   = a;
    bus.in2   = b;
    @(negedge clk);
    bus.start = 1'b0;
    bus.in1   = ~a;
    bus.in2   = ~b;
    n  = 1;
    nb = bus.busy ? 1 : 0;
    while (!bus.done && n < 30) begin
      @(negedge clk);
      n++;
      if (bus.busy) nb++;
    end
    chk({tag, " lat"}, 64'(n - 1), 64'd6);
    chk({tag, " busy"}, 64'(nb), 64'd6);
    chk({tag, " out"}, bus.out, eo);
    chk({tag, " z"}, 64'(bus.z_sll_flag), 64'(ez));
    @(negedge clk);
    chk({tag, " pulse"}, 64'(bus.done), 64'd0);
  endtask

  initial begin
    int n;
    int m;
    int cnt;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] e;

    rst       = 1'b1;
    bus.start = 1'b0;
    bus.in1   = '0;
    bus.in2   = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rst out", bus.out, 64'd0);
      chk("rst z", 64'(bus.z_sll_flag), 64'd0);
      chk("rst busy", 64'(bus.busy), 64'd0);
      chk("rst done", 64'(bus.done), 64'd0);
    end

    run_op("sh63", 64'h1, 64'h3F,
           64'h8000_0000_0000_0000, 1'b0);
    run_op("hi_ign", 64'hFFFF_FFFF_FFFF_FFFF, 64'h104,
           64'hFFFF_FFFF_FFFF_FFF0, 1'b0);
    run_op("zero", 64'hF000_0000_0000_0000, 64'd4,
           64'd0, 1'b1);
    run_op("sh0", 64'h1234_5678_9ABC_DEF0, 64'd0,
           64'h1234_5678_9ABC_DEF0, 1'b0);

    // start held high across two requests
    @(negedge clk);
    bus.start = 1'b1;
    bus.in1   = 64'h3;
    bus.in2   = 64'd1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        bus.in1 = 64'h1;
        bus.in2 = 64'd32;
      end
    end while (!bus.done && n < 30);
    chk("b2b a lat", 64'(n - 1), 64'd6);
    chk("b2b a out", bus.out, 64'h6);
    m = 0;
    do begin
      @(negedge clk);
      m++;
    end while (!bus.done && m < 30);
    bus.start = 1'b0;
    chk("b2b gap", 64'(m), 64'd7);
    chk("b2b b out", bus.out, 64'h1_0000_0000);
    chk("b2b b z", 64'(bus.z_sll_flag), 64'd0);
    @(negedge clk);
    chk("b2b idle", 64'(bus.done), 64'd0);

    // start pulse during SHIFT must be ignored
    @(negedge clk);
    bus.start = 1'b1;
    bus.in1   = 64'h5;
    bus.in2   = 64'd2;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.in1   = 64'h7;
    bus.in2   = 64'd1;
    @(negedge clk);
    bus.start = 1'b0;
    n = 3;
    while (!bus.done && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk("ign lat", 64'(n - 1), 64'd6);
    chk("ign out", bus.out, 64'h14);
    cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.done) cnt++;
    end
    chk("ign extra", 64'(cnt), 64'd0);

    // reset during the 3rd SHIFT cycle aborts
    @(negedge clk);
    bus.start = 1'b1;
    bus.in1   = 64'hFF;
    bus.in2   = 64'd8;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort busy", 64'(bus.busy), 64'd0);
    chk("abort done", 64'(bus.done), 64'd0);
    chk("abort out", bus.out, 64'd0);
    chk("abort z", 64'(bus.z_sll_flag), 64'd0);
    cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.done || bus.busy) cnt++;
    end
    chk("abort quiet", 64'(cnt), 64'd0);
    run_op("fresh", 64'hFF, 64'd8, 64'hFF00, 1'b0);

    for (int i = 0; i < 1000; i++) begin
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      if (i % 10 == 0) a = a & 64'hFF;
      e = a << b[5:0];
      run_op("rand", a, b, e, e == 64'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end
endmodule
